// File: rtl/prefetch_queue_pkg.sv
// Shared definitions for the prefetch queue.
//  WORD_WIDTH    default data word width
//  up_state_t    upstream request FSM states
//  level_changed two-phase handshake helper: any level change is an event
package prefetch_queue_pkg;

    localparam int WORD_WIDTH = 32;

    typedef enum logic {
        ST_IDLE = 1'b0,   // no upstream request outstanding
        ST_WAIT = 1'b1    // request issued, waiting for readyIn toggle
    } up_state_t;

    function automatic logic level_changed(input logic now_level, input logic last_level);
        return now_level != last_level;
    endfunction

endpackage

// File: rtl/prefetch_queue_if.sv
// Bundle of the prefetch queue's handshake, data and status signals.
//  slave  : the queue's view (drives triggerOut, readyOut, dataOut, count, full, empty)
//  master : the environment's view (drives flush, readyIn, dataIn, triggerIn)
interface prefetch_queue_if #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic             flush;
    logic             triggerOut;
    logic             readyIn;
    logic [WIDTH-1:0] dataIn;
    logic             triggerIn;
    logic             readyOut;
    logic [WIDTH-1:0] dataOut;
    logic [CW-1:0]    count;
    logic             full;
    logic             empty;

    modport slave (
        input  flush, readyIn, dataIn, triggerIn,
        output triggerOut, readyOut, dataOut, count, full, empty
    );

    modport master (
        output flush, readyIn, dataIn, triggerIn,
        input  triggerOut, readyOut, dataOut, count, full, empty
    );
endinterface

// File: rtl/prefetch_queue_toggle_event.sv
// Turns a two-phase toggle input into a one-cycle event pulse.
//  clk     : clock
//  reset   : asynchronous, active-high
//  i_level : toggle input (may come from another domain when SYNC > 0)
//  o_event : high for the cycle in which the synchronised level differs
//            from the level seen on the previous edge
module prefetch_queue_toggle_event
    import prefetch_queue_pkg::*;
#(
    parameter int SYNC = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic i_level,
    output logic o_event
);
    logic w_sync_level;
    logic r_last_level;

    generate
        if (SYNC == 0) begin : g_direct
            assign w_sync_level = i_level;
        end else begin : g_sync
            logic [SYNC-1:0] r_sync;
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    r_sync <= '0;
                end else begin
                    r_sync[0] <= i_level;
                    for (int i = 1; i < SYNC; i++) begin
                        r_sync[i] <= r_sync[i-1];
                    end
                end
            end
            assign w_sync_level = r_sync[SYNC-1];
        end
    endgenerate

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_last_level <= 1'b0;
        end else begin
            r_last_level <= w_sync_level;
        end
    end

    assign o_event = level_changed(w_sync_level, r_last_level);
endmodule

// File: rtl/prefetch_queue.sv
// Elastic prefetch buffer between a fetch unit (upstream) and a decoder
// (downstream), both speaking the two-phase toggle handshake.
//  clk   : clock, all state updates on the rising edge
//  reset : asynchronous, active-high; peers must be reset too (toggle phase restarts at 0)
//  bus   : prefetch_queue_if.slave
//          flush      discard queued words and any in-flight response
//          triggerOut/readyIn/dataIn    upstream request/response/word
//          triggerIn/readyOut/dataOut   downstream request/response/word
//          count/full/empty             occupancy
module prefetch_queue
    import prefetch_queue_pkg::*;
#(
    parameter int WIDTH = WORD_WIDTH,
    parameter int DEPTH = 4,
    parameter int SYNC  = 2
) (
    input  logic clk,
    input  logic reset,
    prefetch_queue_if.slave bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic w_ready_ev;
    logic w_trig_ev;

    prefetch_queue_toggle_event #(.SYNC(SYNC)) u_ready_ev (
        .clk     (clk),
        .reset   (reset),
        .i_level (bus.readyIn),
        .o_event (w_ready_ev)
    );

    prefetch_queue_toggle_event #(.SYNC(SYNC)) u_trig_ev (
        .clk     (clk),
        .reset   (reset),
        .i_level (bus.triggerIn),
        .o_event (w_trig_ev)
    );

    logic [WIDTH-1:0] r_mem [DEPTH];

    up_state_t        r_state, w_state_next;
    logic [PW-1:0]    r_head, w_head_next;
    logic [PW-1:0]    r_tail, w_tail_next;
    logic [CW-1:0]    r_count, w_count_next;
    logic             r_drop, w_drop_next;
    logic             r_pend, w_pend_next;
    logic             r_trig_out, w_trig_out_next;
    logic             r_ready_out;
    logic [WIDTH-1:0] r_data_out;
    logic             w_push;
    logic             w_pop;

    always_comb begin
        // flush overrides both directions in the cycle it is seen
        w_push          = (r_state == ST_WAIT) && w_ready_ev && !r_drop && !bus.flush;
        w_pop           = r_pend && (r_count != '0) && !bus.flush;
        w_state_next    = r_state;
        w_drop_next     = r_drop;
        w_trig_out_next = r_trig_out;
        w_pend_next     = r_pend;
        w_head_next     = r_head;
        w_tail_next     = r_tail;
        w_count_next    = r_count;

        case (r_state)
            ST_IDLE: begin
                // Only one request is ever outstanding, so a free slot now
                // is still free when the response lands.
                if ((r_count < CW'(DEPTH)) && !bus.flush) begin
                    w_state_next    = ST_WAIT;
                    w_trig_out_next = ~r_trig_out;
                end
            end
            ST_WAIT: begin
                if (w_ready_ev) begin
                    // The response closes the request whether kept or discarded
                    w_state_next = ST_IDLE;
                    w_drop_next  = 1'b0;
                end else if (bus.flush) begin
                    w_drop_next = 1'b1;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase

        // A second request while one is pending is ignored
        if (w_pop) begin
            w_pend_next = 1'b0;
        end else if (w_trig_ev) begin
            w_pend_next = 1'b1;
        end

        if (bus.flush) begin
            w_head_next  = '0;
            w_tail_next  = '0;
            w_count_next = '0;
        end else begin
            w_head_next  = r_head + PW'(w_pop);
            w_tail_next  = r_tail + PW'(w_push);
            w_count_next = r_count + CW'(w_push) - CW'(w_pop);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_head      <= '0;
            r_tail      <= '0;
            r_count     <= '0;
            r_drop      <= 1'b0;
            r_pend      <= 1'b0;
            r_trig_out  <= 1'b0;
            r_ready_out <= 1'b0;
            r_data_out  <= '0;
        end else begin
            r_state    <= w_state_next;
            r_head     <= w_head_next;
            r_tail     <= w_tail_next;
            r_count    <= w_count_next;
            r_drop     <= w_drop_next;
            r_pend     <= w_pend_next;
            r_trig_out <= w_trig_out_next;
            if (w_pop) begin
                r_data_out  <= r_mem[r_head];
                r_ready_out <= ~r_ready_out;
            end
        end
    end

    // Storage has no reset; occupancy is tracked solely by r_count
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_tail] <= bus.dataIn;
        end
    end

    assign bus.triggerOut = r_trig_out;
    assign bus.readyOut   = r_ready_out;
    assign bus.dataOut    = r_data_out;
    assign bus.count      = r_count;
    assign bus.full       = (r_count == CW'(DEPTH));
    assign bus.empty      = (r_count == '0);
endmodule

// File: tb/tb_prefetch_queue.sv
`timescale 1ns/1ps
module tb_prefetch_queue;
    localparam int WIDTH = 32;
    localparam int DEPTH = 4;
    localparam int SYNC  = 2;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    prefetch_queue_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) pq ();

    prefetch_queue #(.WIDTH(WIDTH), .DEPTH(DEPTH), .SYNC(SYNC)) dut (
        .clk   (clk),
        .reset (rst),
        .bus   (pq)
    );

    // ---------------------------------------------------------------- helpers
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h required 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Producer ROM: MOV rK,#K+1 style words 0xE3A00001, 0xE3A01002, ...
    function automatic logic [31:0] rom(input int k);
        logic [31:0] kk;
        kk = k;
        return 32'hE3A00000 | ((kk & 32'hF) << 12) | ((kk + 32'd1) & 32'hFFF);
    endfunction

    logic [31:0] s2_exp [6] = '{32'hE3A00001, 32'hE3A01002, 32'hE3A02003,
                                32'hE3A03004, 32'hE3A04005, 32'hE3A05006};

    // ---------------------------------------------------------------- peers
    bit          p_seen, p_busy, c_seen, c_busy, last_tout, flush_force;
    int          p_wait, prod_fixed, prod_max, prod_allow, rom_idx;
    int          c_wait, cons_left, cons_max, flush_rate;
    int          tout_toggles, rout_toggles;
    logic [31:0] got [$];

    task automatic reset_peers();
        p_seen = 0; p_busy = 0; c_seen = 0; c_busy = 0; last_tout = 0; flush_force = 0;
        p_wait = 0; prod_fixed = -1; prod_max = 3; prod_allow = 1000000; rom_idx = 0;
        c_wait = 0; cons_left = 0; cons_max = 3; flush_rate = 0;
        tout_toggles = 0; rout_toggles = 0;
        got.delete();
        pq.flush = 1'b0; pq.readyIn = 1'b0; pq.triggerIn = 1'b0; pq.dataIn = '0;
    endtask

    // One cycle of producer/consumer behaviour, run just after the rising edge
    task automatic drive_cycle();
        if (pq.triggerOut != last_tout) begin
            last_tout = pq.triggerOut;
            tout_toggles++;
        end
        if (!p_busy && pq.triggerOut != p_seen) begin
            p_seen = pq.triggerOut;
            p_busy = 1;
            p_wait = (prod_fixed >= 0) ? prod_fixed : int'($urandom_range(0, prod_max));
        end
        if (p_busy && prod_allow > 0) begin
            if (p_wait == 0) begin
                pq.dataIn  = rom(rom_idx);
                rom_idx++;
                pq.readyIn = ~pq.readyIn;
                p_busy     = 0;
                prod_allow--;
            end else begin
                p_wait--;
            end
        end
        if (pq.readyOut != c_seen) begin
            c_seen = pq.readyOut;
            c_busy = 0;
            got.push_back(pq.dataOut);
            rout_toggles++;
            $display("xfer %0d data=0x%08h count=%0d", rout_toggles, pq.dataOut, pq.count);
        end
        if (!c_busy && cons_left > 0) begin
            if (c_wait <= 0) begin
                pq.triggerIn = ~pq.triggerIn;
                c_busy = 1;
                cons_left--;
                c_wait = int'($urandom_range(0, cons_max));
            end else begin
                c_wait--;
            end
        end
        pq.flush = flush_force || (flush_rate > 0 && int'($urandom_range(0, 99)) < flush_rate);
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            drive_cycle();
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        reset_peers();
        tick(2);
        rst = 1'b0;
    endtask

    task automatic wait_got(input int n, input int budget);
        int k;
        k = 0;
        while (got.size() < n && k < budget) begin
            tick(1);
            k++;
        end
        checks++;
        if (got.size() < n) begin
            failures++;
            $display("FAIL timeout: got %0d words required %0d", got.size(), n);
        end
    endtask

    // ---------------------------------------------------------------- model
    // Queue-level reference: contents as an ordered list, one outstanding
    // request flag, handshake levels delayed by SYNC sampled edges.
    bit          m_busy, m_drop, m_pend, m_tout, m_rout;
    logic [31:0] m_dout;
    logic [31:0] m_q [$];
    logic [SYNC+1:0] m_rh, m_th;

    task automatic model_reset();
        m_busy = 0; m_drop = 0; m_pend = 0; m_tout = 0; m_rout = 0;
        m_dout = '0; m_rh = '0; m_th = '0;
        m_q.delete();
    endtask

    task automatic model_step();
        bit rev, tev, fl, push, pop;
        int sz;
        m_rh = {m_rh[SYNC:0], pq.readyIn};
        m_th = {m_th[SYNC:0], pq.triggerIn};
        rev  = m_rh[SYNC] != m_rh[SYNC+1];
        tev  = m_th[SYNC] != m_th[SYNC+1];
        fl   = pq.flush;
        sz   = m_q.size();
        push = m_busy && rev && !m_drop && !fl;
        pop  = m_pend && sz > 0 && !fl;
        if (pop) begin
            m_dout = m_q[0];
            m_rout = ~m_rout;
        end
        if (fl) begin
            m_q.delete();
        end else begin
            if (pop)  void'(m_q.pop_front());
            if (push) m_q.push_back(pq.dataIn);
        end
        if (m_busy) begin
            if (rev) begin
                m_busy = 0;
                m_drop = 0;
            end else if (fl) begin
                m_drop = 1;
            end
        end else if (sz < DEPTH && !fl) begin
            m_busy = 1;
            m_tout = ~m_tout;
        end
        if (pop) m_pend = 0;
        else if (tev) m_pend = 1;
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk or posedge rst);
            if (rst) model_reset();
            else     model_step();
        end
    end

    // Cycle compare on the falling edge
    initial begin
        forever begin
            @(negedge clk);
            if (!rst) begin
                check("cyc triggerOut", 32'(pq.triggerOut), 32'(m_tout));
                check("cyc readyOut",   32'(pq.readyOut),   32'(m_rout));
                check("cyc dataOut",    pq.dataOut,         m_dout);
                check("cyc count",      32'(pq.count),      32'(m_q.size()));
                check("cyc full",       32'(pq.full),       32'(m_q.size() == DEPTH));
                check("cyc empty",      32'(pq.empty),      32'(m_q.size() == 0));
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------------------------------------------------------- stimulus
    initial begin
        int ck, cr;
        reset_peers();
        #1 rst = 1'b1;
        #1;
        check("reset triggerOut", 32'(pq.triggerOut), 32'd0);
        check("reset readyOut",   32'(pq.readyOut),   32'd0);
        check("reset dataOut",    pq.dataOut,         32'd0);
        check("reset count",      32'(pq.count),      32'd0);
        check("reset empty",      32'(pq.empty),      32'd1);
        check("reset full",       32'(pq.full),       32'd0);
        tick(2);
        rst = 1'b0;

        // Fill with no consumer: exactly DEPTH requests
        tick(60);
        check("s1 request toggles", 32'(tout_toggles), 32'd4);
        check("s1 count",           32'(pq.count),     32'd4);
        check("s1 full",            32'(pq.full),      32'd1);

        // Drain six words while the producer refills
        cons_left = 6;
        wait_got(6, 400);
        for (int i = 0; i < 6; i++) begin
            if (i < got.size()) check("s2 word order", got[i], s2_exp[i]);
        end
        tick(20);
        check("s2 response toggles", 32'(rout_toggles), 32'd6);

        // Pending request on empty queue, slow producer
        do_reset();
        prod_fixed = 10;
        cons_left  = 1;
        ck = -1;
        cr = -1;
        for (int n = 0; n < 100 && cr < 0; n++) begin
            tick(1);
            if (ck < 0 && 32'(pq.count) == 32'd1) ck = n;
            if (cr < 0 && pq.readyOut) cr = n;
        end
        check("s3 write-to-response latency", 32'(cr - ck), 32'd1);
        check("s3 first word", pq.dataOut, rom(0));

        // Flush while waiting on a response with two words queued
        do_reset();
        prod_fixed = 0;
        prod_allow = 2;
        for (int n = 0; n < 100 && 32'(pq.count) != 32'd2; n++) tick(1);
        check("s4 count before flush", 32'(pq.count), 32'd2);
        tick(4);
        check("s4 third request issued", 32'(pq.triggerOut), 32'd1);
        flush_force = 1;
        tick(1);
        flush_force = 0;
        tick(1);
        check("s4 count after flush", 32'(pq.count), 32'd0);
        check("s4 empty after flush", 32'(pq.empty), 32'd1);
        prod_allow = 1000000;
        cons_left  = 1;
        wait_got(1, 200);
        if (got.size() > 0) check("s4 first word after flush", got[0], rom(3));

        // Streaming across pointer wrap, no flush: strict ROM order
        do_reset();
        prod_fixed = 0;
        cons_max   = 0;
        cons_left  = 40;
        wait_got(40, 1500);
        for (int i = 0; i < 40; i++) begin
            if (i < got.size()) check("s5 stream order", got[i], rom(i));
        end

        // Random traffic with flushes; cycle compare does the checking
        do_reset();
        prod_max   = 5;
        cons_max   = 5;
        flush_rate = 4;
        cons_left  = 300;
        tick(1500);
        flush_rate = 0;
        tick(20);

        // Asynchronous reset while waiting, with readyOut high
        do_reset();
        prod_allow = 2;
        cons_left  = 1;
        wait_got(1, 200);
        tick(10);
        check("s6 pre readyOut",   32'(pq.readyOut),   32'd1);
        check("s6 pre triggerOut", 32'(pq.triggerOut), 32'd1);
        check("s6 pre count",      32'(pq.count),      32'd1);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("s6 async triggerOut", 32'(pq.triggerOut), 32'd0);
        check("s6 async readyOut",   32'(pq.readyOut),   32'd0);
        check("s6 async dataOut",    pq.dataOut,         32'd0);
        check("s6 async count",      32'(pq.count),      32'd0);
        check("s6 async empty",      32'(pq.empty),      32'd1);
        check("s6 async full",       32'(pq.full),       32'd0);
        reset_peers();
        tick(2);
        rst = 1'b0;
        cons_left = 1;
        wait_got(1, 200);
        if (got.size() > 0) check("s6 restart word", got[0], rom(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
